// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file and its debug dump sequencer.
// Holds the dump FSM encoding, default geometry and the flattened-bus field extractor.
package regfile_pkg;

   typedef enum logic {
      DUMP_IDLE   = 1'b0,
      DUMP_STREAM = 1'b1
   } dump_state_e;

   localparam int unsigned DEF_WIDTH    = 32;
   localparam int unsigned DEF_ADDR_W   = 5;
   localparam int unsigned DEF_NUM_READ = 2;

   // Widest flattened bus the extractor accepts; callers zero-extend into it.
   localparam int unsigned MAX_BUS_W = 256;

   // Returns field idx of width w from a flattened bus, right-aligned and zero-filled.
   function automatic logic [MAX_BUS_W-1:0] port_field(input logic [MAX_BUS_W-1:0] bus,
                                                       input int unsigned idx,
                                                       input int unsigned w);
      logic [MAX_BUS_W-1:0] mask;
      mask = ~({MAX_BUS_W{1'b1}} << w);
      return (bus >> (idx * w)) & mask;
   endfunction

endpackage

// File: rtl/regfile_dump_seq.sv
// Debug dump sequencer: walks every register address and presents a snapshot of each
// over a valid/ready handshake. Storage is read through a mux owned by the parent.
module regfile_dump_seq
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              ready_i,
   input  logic [WIDTH-1:0]  rd_data_i,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic              busy_o,
   output logic              valid_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [WIDTH-1:0]  data_o,
   output logic              last_o
);

   localparam logic [ADDR_W-1:0] LastAddr = '1;

   dump_state_e       state_q;
   logic              valid_q;
   logic [ADDR_W-1:0] addr_q;
   logic [WIDTH-1:0]  data_q;

   // Look one entry ahead so the next capture edge already sees the right register.
   assign rd_addr_o = (state_q == DUMP_STREAM) ? addr_q + ADDR_W'(1) : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= DUMP_IDLE;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         case (state_q)
            DUMP_IDLE: begin
               if (start_i) begin
                  state_q <= DUMP_STREAM;
                  valid_q <= 1'b1;
                  addr_q  <= '0;
                  data_q  <= rd_data_i;
               end
            end
            DUMP_STREAM: begin
               if (abort_i) begin
                  state_q <= DUMP_IDLE;
                  valid_q <= 1'b0;
               end else if (valid_q && ready_i) begin
                  if (addr_q == LastAddr) begin
                     state_q <= DUMP_IDLE;
                     valid_q <= 1'b0;
                  end else begin
                     addr_q <= addr_q + ADDR_W'(1);
                     data_q <= rd_data_i;
                  end
               end
            end
            default: begin
               state_q <= DUMP_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o  = (state_q == DUMP_STREAM);
   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;
   assign last_o  = valid_q && (addr_q == LastAddr);

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-read-port register file with optional write bypass and hardwired
// zero register, plus a snapshot dump port for the test harness and debug bridge.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned NUM_READ = DEF_NUM_READ,
   parameter bit          BYPASS   = 1'b1,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                       Clk,
   input  logic                       Rst_n,
   input  logic [WIDTH-1:0]           WriteData,
   input  logic [ADDR_W-1:0]          WriteRegister,
   input  logic                       RegWrite,
   input  logic [NUM_READ*ADDR_W-1:0] ReadRegister,
   output logic [NUM_READ*WIDTH-1:0]  ReadData,
   input  logic                       DumpStart,
   input  logic                       DumpAbort,
   output logic                       DumpBusy,
   output logic                       DumpValid,
   input  logic                       DumpReady,
   output logic [ADDR_W-1:0]          DumpAddr,
   output logic [WIDTH-1:0]           DumpData,
   output logic                       DumpLast
);

   localparam int DEPTH = 2 ** ADDR_W;

   if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
      $error("regfile_param: NUM_READ must be in 1..4");
   end
   if (NUM_READ * ADDR_W > MAX_BUS_W) begin : g_bad_addr_bus
      $error("regfile_param: read address bus exceeds MAX_BUS_W");
   end

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic             wr_en;

   assign wr_en = RegWrite && !(ZERO_REG && (WriteRegister == '0));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[WriteRegister] <= WriteData;
      end
   end

   for (genvar g = 0; g < NUM_READ; g++) begin : g_read
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  rd_val;

      assign addr = ADDR_W'(port_field(MAX_BUS_W'(ReadRegister), g, ADDR_W));

      // Zero register wins over the bypass path.
      always_comb begin
         rd_val = regs_q[addr];
         if (ZERO_REG && (addr == '0)) begin
            rd_val = '0;
         end else if (BYPASS && RegWrite && (WriteRegister == addr)) begin
            rd_val = WriteData;
         end
      end

      assign ReadData[g*WIDTH +: WIDTH] = rd_val;
   end

   // Dump reads see stored state only, so a same-edge write never leaks into a capture.
   logic [ADDR_W-1:0] dump_rd_addr;
   logic [WIDTH-1:0]  dump_rd_data;

   assign dump_rd_data = (ZERO_REG && (dump_rd_addr == '0)) ? '0 : regs_q[dump_rd_addr];

   regfile_dump_seq #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_dump_seq (
      .clk_i     (Clk),
      .rst_ni    (Rst_n),
      .start_i   (DumpStart),
      .abort_i   (DumpAbort),
      .ready_i   (DumpReady),
      .rd_data_i (dump_rd_data),
      .rd_addr_o (dump_rd_addr),
      .busy_o    (DumpBusy),
      .valid_o   (DumpValid),
      .addr_o    (DumpAddr),
      .data_o    (DumpData),
      .last_o    (DumpLast)
   );

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: directed scenarios plus random traffic against an array-based model.
// Instance a uses the defaults (bypass, zero register); instance b has neither.
module tb_regfile_param;

   localparam int W     = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int DEPTH = 32;

   logic             Clk = 1'b0;
   logic             Rst_n;
   logic [W-1:0]     WriteData;
   logic [AW-1:0]    WriteRegister;
   logic             RegWrite;
   logic [NR*AW-1:0] ReadRegister;
   logic [NR*W-1:0]  ReadData_a, ReadData_b;
   logic             DumpStart, DumpAbort, DumpReady;
   logic             DumpBusy, DumpValid, DumpLast;
   logic [AW-1:0]    DumpAddr;
   logic [W-1:0]     DumpData;
   logic             b_busy, b_valid, b_last;
   logic [AW-1:0]    b_addr;
   logic [W-1:0]     b_data;

   always #5 Clk = ~Clk;

   regfile_param dut (
      .Clk(Clk), .Rst_n(Rst_n), .WriteData(WriteData), .WriteRegister(WriteRegister),
      .RegWrite(RegWrite), .ReadRegister(ReadRegister), .ReadData(ReadData_a),
      .DumpStart(DumpStart), .DumpAbort(DumpAbort), .DumpBusy(DumpBusy),
      .DumpValid(DumpValid), .DumpReady(DumpReady), .DumpAddr(DumpAddr),
      .DumpData(DumpData), .DumpLast(DumpLast)
   );

   regfile_param #(.WIDTH(W), .ADDR_W(AW), .NUM_READ(NR), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b (
      .Clk(Clk), .Rst_n(Rst_n), .WriteData(WriteData), .WriteRegister(WriteRegister),
      .RegWrite(RegWrite), .ReadRegister(ReadRegister), .ReadData(ReadData_b),
      .DumpStart(DumpStart), .DumpAbort(DumpAbort), .DumpBusy(b_busy),
      .DumpValid(b_valid), .DumpReady(DumpReady), .DumpAddr(b_addr),
      .DumpData(b_data), .DumpLast(b_last)
   );

   int n_checks = 0;
   int n_err    = 0;

   logic [W-1:0] mem_a [DEPTH];
   logic [W-1:0] mem_b [DEPTH];
   bit           exp_busy;
   int           exp_addr;
   logic [W-1:0] exp_data, exp_data_b;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      exp_busy   = 1'b0;
      exp_addr   = 0;
      exp_data   = '0;
      exp_data_b = '0;
   endtask

   function automatic logic [W-1:0] ref_read_a(input int a);
      if (a == 0) return '0;
      if (RegWrite && int'(WriteRegister) == a) return WriteData;
      return mem_a[a];
   endfunction

   task automatic check_reads();
      for (int p = 0; p < NR; p++) begin
         int a;
         a = int'(ReadRegister[p*AW +: AW]);
         check("read_a", ReadData_a[p*W +: W], ref_read_a(a));
         check("read_b", ReadData_b[p*W +: W], mem_b[a]);
      end
   endtask

   task automatic check_dump();
      check("dump_valid", DumpValid, exp_busy);
      check("dump_busy", DumpBusy, exp_busy);
      check("dump_addr", DumpAddr, exp_addr);
      check("dump_data", DumpData, exp_data);
      check("dump_last", DumpLast, exp_busy && exp_addr == DEPTH - 1);
      check("dump_b_data", b_data, exp_data_b);
      check("dump_b_ctrl", {b_valid, b_busy, b_last, b_addr},
            {exp_busy, exp_busy, exp_busy && exp_addr == DEPTH - 1, AW'(exp_addr)});
   endtask

   // Advance the model by one edge from the inputs now applied, then clock and compare.
   task automatic tick();
      if (exp_busy) begin
         if (DumpAbort) begin
            exp_busy = 1'b0;
         end else if (DumpReady) begin
            if (exp_addr == DEPTH - 1) begin
               exp_busy = 1'b0;
            end else begin
               exp_addr++;
               exp_data   = mem_a[exp_addr];
               exp_data_b = mem_b[exp_addr];
            end
         end
      end else if (DumpStart) begin
         exp_busy   = 1'b1;
         exp_addr   = 0;
         exp_data   = '0;
         exp_data_b = mem_b[0];
      end
      if (RegWrite) begin
         if (WriteRegister != '0) mem_a[WriteRegister] = WriteData;
         mem_b[WriteRegister] = WriteData;
      end
      @(posedge Clk);
      #1;
      check_dump();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst_n = 1'b1;
      WriteData = '0; WriteRegister = '0; RegWrite = 1'b0; ReadRegister = '0;
      DumpStart = 1'b0; DumpAbort = 1'b0; DumpReady = 1'b0;
      model_reset();
      #1 Rst_n = 1'b0;
      #2;
      check("rst_read_a", ReadData_a, 64'h0);
      check("rst_read_b", ReadData_b, 64'h0);
      check_dump();
      @(posedge Clk);
      #1 Rst_n = 1'b1;

      // Basic write/read and zero register.
      RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'hDEADBEEF;
      tick();
      WriteRegister = 5'd0; WriteData = 32'h1234;
      tick();
      RegWrite = 1'b0;
      ReadRegister = {5'd0, 5'd5};
      #1;
      check("r5_port0", ReadData_a[31:0], 32'hDEADBEEF);
      check("r0_port1_zero", ReadData_a[63:32], 32'h0);
      check("r0_port1_plain", ReadData_b[63:32], 32'h1234);
      check_reads();

      // Same-cycle bypass versus plain read.
      RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'hA5A5A5A5;
      ReadRegister = {5'd7, 5'd0};
      #1;
      check("bypass_p1", ReadData_a[63:32], 32'hA5A5A5A5);
      check("no_bypass_p1", ReadData_b[63:32], 32'h0);
      check_reads();
      tick();
      RegWrite = 1'b0;
      #1;
      check("no_bypass_after", ReadData_b[63:32], 32'hA5A5A5A5);

      // Preload and full dump with ready held.
      RegWrite = 1'b1;
      for (int n = 1; n < DEPTH; n++) begin
         WriteRegister = AW'(n);
         WriteData = 32'(n * 'h11);
         tick();
      end
      RegWrite = 1'b0;
      DumpStart = 1'b1; DumpReady = 1'b1;
      tick();
      DumpStart = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         check("full_addr", DumpAddr, k);
         check("full_data", DumpData, k * 'h11);
         check("full_last", DumpLast, k == DEPTH - 1);
         tick();
      end
      check("full_busy_after", DumpBusy, 1'b0);
      check("full_valid_after", DumpValid, 1'b0);

      // Stalled dump with snapshot semantics.
      DumpReady = 1'b0; DumpStart = 1'b1;
      tick();
      DumpStart = 1'b0;
      for (int c = 0; c < 5; c++) begin
         DumpReady = (c % 2 == 0);
         tick();
      end
      check("stall_addr3", DumpAddr, 3);
      DumpReady = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'hFFFF;
      tick();
      check("stall_snapshot", DumpData, 32'h33);
      WriteRegister = 5'd4;
      tick();
      check("stall_snapshot2", DumpData, 32'h33);
      RegWrite = 1'b0; DumpReady = 1'b1;
      tick();
      check("late_capture_addr", DumpAddr, 4);
      check("late_capture_data", DumpData, 32'hFFFF);
      for (int c = 0; c < 80 && exp_busy; c++) begin
         DumpReady = (c % 2 == 0);
         tick();
      end
      check("toggle_done", DumpBusy, 1'b0);

      // Abort has priority over the handshake; restart begins at 0.
      DumpStart = 1'b1; DumpReady = 1'b1;
      tick();
      DumpStart = 1'b0;
      for (int c = 0; c < 40 && exp_addr != 10; c++) tick();
      check("abort_at", DumpAddr, 10);
      DumpAbort = 1'b1;
      tick();
      DumpAbort = 1'b0;
      check("abort_valid", DumpValid, 1'b0);
      check("abort_busy", DumpBusy, 1'b0);
      DumpStart = 1'b1;
      tick();
      DumpStart = 1'b0;
      check("restart_addr", DumpAddr, 0);
      check("restart_valid", DumpValid, 1'b1);
      DumpAbort = 1'b1;
      tick();
      DumpAbort = 1'b0;

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         RegWrite      = 1'($urandom);
         WriteRegister = AW'($urandom);
         WriteData     = $urandom;
         ReadRegister  = (NR*AW)'($urandom);
         if ($urandom_range(3) == 0) ReadRegister[AW-1:0] = WriteRegister;
         if ($urandom_range(3) == 0) ReadRegister[2*AW-1:AW] = WriteRegister;
         DumpStart = ($urandom_range(7) == 0);
         DumpAbort = ($urandom_range(23) == 0);
         DumpReady = 1'($urandom);
         #1;
         check_reads();
         tick();
      end

      // Asynchronous reset in the middle of a dump.
      RegWrite = 1'b0; DumpAbort = 1'b0; DumpStart = 1'b0; DumpReady = 1'b1;
      for (int c = 0; c < 4 && exp_busy; c++) begin
         DumpAbort = 1'b1;
         tick();
      end
      DumpAbort = 1'b0; DumpStart = 1'b1;
      tick();
      DumpStart = 1'b0;
      for (int c = 0; c < 40 && exp_addr != 20; c++) tick();
      check("rst_dump_at", DumpAddr, 20);
      #2 Rst_n = 1'b0;
      #1;
      check("async_rst_valid", DumpValid, 1'b0);
      check("async_rst_busy", DumpBusy, 1'b0);
      check("async_rst_addr", DumpAddr, 0);
      check("async_rst_data", DumpData, 32'h0);
      model_reset();
      @(posedge Clk);
      #1 Rst_n = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
         ReadRegister = {AW'(DEPTH - 1 - a), AW'(a)};
         #1;
         check("post_rst_a", ReadData_a, 64'h0);
         check("post_rst_b", ReadData_b, 64'h0);
      end
      check_dump();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
